// File: rtl/sda_to_parallel.sv
// sda_to_parallel: receiver for the scl/sda serial link from the P2S converter.
// Oversamples scl/sda on sclk and detects START (sda falls while scl high) and STOP (sda rises while scl high).
// Shifts in NBITS data bits MSB first and emits the word with a one-cycle data_valid strobe.
// Aborted frames produce a one-cycle frame_err strobe instead and leave data_out untouched.
// Optional feature: define SDA_TO_PARALLEL_ONEHOT_EN to add onehot_out, a registered one-hot decode of data_out.
module sda_to_parallel #(
  parameter int unsigned NBITS       = 4,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             scl,
  input  logic             sda,
  output logic [NBITS-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
`ifdef SDA_TO_PARALLEL_ONEHOT_EN
  ,
  output logic [(1<<NBITS)-1:0] onehot_out
`endif
);

  localparam int unsigned CW  = $clog2(NBITS + 1);
  localparam int unsigned WW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned OHW = 1 << NBITS;

  typedef enum logic [1:0] {IDLE, RECV, WAIT_STOP} state_t;

  state_t           state;
  logic             s_scl, s_sda, p_sda, ps_scl;
  logic [CW-1:0]    cnt;
  logic [NBITS-1:0] shreg;
  logic [WW-1:0]    wd;
  logic             is_start, is_stop, is_bit, wd_expire;

  // Line sampling: one-cycle sample of scl/sda plus the previous sample of each.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      s_scl  <= 1'b1;
      s_sda  <= 1'b1;
      p_sda  <= 1'b1;
      ps_scl <= 1'b1;
    end else begin
      s_scl  <= scl;
      s_sda  <= sda;
      p_sda  <= s_sda;
      ps_scl <= s_scl;
    end
  end

  // Classify the current sample; only the first high sample of an scl phase can be a data bit.
  always_comb begin
    is_start  = s_scl & p_sda & ~s_sda;
    is_stop   = s_scl & ~p_sda & s_sda;
    is_bit    = s_scl & (s_sda == p_sda) & ~ps_scl;
    wd_expire = ~s_scl & (wd == WW'(TIMEOUT_CYC - 1));
  end

  // Frame FSM with watchdog; all outputs registered, strobes default low every cycle.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      wd         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef SDA_TO_PARALLEL_ONEHOT_EN
      onehot_out <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          wd <= '0;
          if (is_start) begin
            state <= RECV;
            cnt   <= '0;
            shreg <= '0;
            busy  <= 1'b1;
          end
        end
        RECV, WAIT_STOP: begin
          // Watchdog cleared by any scl-high sample, saturating otherwise.
          if (s_scl)
            wd <= '0;
          else if (wd < WW'(TIMEOUT_CYC))
            wd <= wd + 1'b1;

          if (wd_expire) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            wd        <= '0;
          end else if (is_start) begin
            frame_err <= 1'b1;
            state     <= RECV;
            cnt       <= '0;
            shreg     <= '0;
          end else if (state == RECV) begin
            if (is_stop) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else if (is_bit) begin
              shreg <= (shreg << 1) | NBITS'(s_sda);
              cnt   <= cnt + 1'b1;
              if (cnt == CW'(NBITS - 1))
                state <= WAIT_STOP;
            end
          end else begin
            if (is_stop) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
`ifdef SDA_TO_PARALLEL_ONEHOT_EN
              onehot_out <= {{(OHW-1){1'b0}}, 1'b1} << shreg;
`endif
            end else if (is_bit) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
